// File: rtl/stb_seq_ctrl.sv
// stb_seq_ctrl: sequences one stb_gen through detect, arm and run,
// counts strobe pulses and reports completion or a coded error.
module stb_seq_ctrl #(
    parameter int T_CNT_WIDTH = 32,
    parameter int N_WIDTH     = 16,
    parameter int TMO_WIDTH   = 32
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [N_WIDTH-1:0]     n_stb_i,
    input  logic [TMO_WIDTH-1:0]   tmo_i,
    input  logic                   oe_en_i,
    output logic                   run_det_o,
    output logic                   stb_req_o,
    output logic                   oe_o,
    input  logic                   rdy_i,
    input  logic                   err_i,
    input  logic                   stb_valid_i,
    input  logic                   stb_i,
    input  logic [T_CNT_WIDTH-1:0] stb_period_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [2:0]             err_code_o,
    output logic [T_CNT_WIDTH-1:0] period_o,
    output logic [N_WIDTH-1:0]     stb_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DETECT, S_ARM, S_RUN, S_DONE, S_ERROR
    } state_t;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_GEN   = 3'd1;
    localparam logic [2:0] E_DET   = 3'd2;
    localparam logic [2:0] E_LOCK  = 3'd3;
    localparam logic [2:0] E_STB   = 3'd4;
    localparam logic [2:0] E_LOST  = 3'd5;
    localparam logic [2:0] E_ABORT = 3'd6;

    state_t                 state_q, state_n;
    logic [N_WIDTH-1:0]     n_stb_q, n_stb_n;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_n;
    logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_n;
    logic                   oe_en_q, oe_en_n;
    logic                   stb_q;
    logic [N_WIDTH-1:0]     cnt_n, cnt_inc;
    logic [T_CNT_WIDTH-1:0] period_n;
    logic                   err_n;
    logic [2:0]             code_n, fail_code;
    logic                   fail, zdone, active, stb_rise, expired;

    always_comb begin
        state_n   = state_q;
        n_stb_n   = n_stb_q;
        tmo_n     = tmo_q;
        oe_en_n   = oe_en_q;
        tmo_cnt_n = tmo_cnt_q;
        cnt_n     = stb_cnt_o;
        period_n  = period_o;
        err_n     = err_o;
        code_n    = err_code_o;
        zdone     = 1'b0;
        fail      = 1'b0;
        fail_code = E_NONE;
        active    = state_q inside {S_DETECT, S_ARM, S_RUN};
        stb_rise  = stb_i & ~stb_q;
        expired   = (tmo_q != '0) && (tmo_cnt_q == tmo_q - 1'b1);
        cnt_inc   = (&stb_cnt_o) ? stb_cnt_o : stb_cnt_o + 1'b1;
        if (active) tmo_cnt_n = tmo_cnt_q + 1'b1;

        if (active && abort_i) begin
            fail      = 1'b1;
            fail_code = E_ABORT;
        end else if (active && err_i) begin
            fail      = 1'b1;
            fail_code = E_GEN;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && n_stb_i != '0) begin
                        n_stb_n   = n_stb_i;
                        tmo_n     = tmo_i;
                        oe_en_n   = oe_en_i;
                        err_n     = 1'b0;
                        code_n    = E_NONE;
                        cnt_n     = '0;
                        tmo_cnt_n = '0;
                        state_n   = S_DETECT;
                    end else if (start_i) begin
                        zdone = 1'b1;
                    end
                end
                S_DETECT: begin
                    if (rdy_i) begin
                        period_n = stb_period_i;
                        state_n  = S_ARM;
                    end else if (expired) begin
                        fail      = 1'b1;
                        fail_code = E_DET;
                    end
                end
                S_ARM: begin
                    if (stb_valid_i) begin
                        state_n = S_RUN;
                    end else if (expired) begin
                        fail      = 1'b1;
                        fail_code = E_LOCK;
                    end
                end
                S_RUN: begin
                    // an edge both counts and restarts the timeout window
                    if (stb_rise) begin
                        cnt_n     = cnt_inc;
                        tmo_cnt_n = '0;
                    end
                    if (stb_rise && cnt_inc == n_stb_q) begin
                        state_n = S_DONE;
                    end else if (!stb_valid_i) begin
                        fail      = 1'b1;
                        fail_code = E_LOST;
                    end else if (!stb_rise && expired) begin
                        fail      = 1'b1;
                        fail_code = E_STB;
                    end
                end
                S_DONE:  state_n = S_IDLE;
                S_ERROR: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        if (fail) begin
            state_n = S_ERROR;
            err_n   = 1'b1;
            code_n  = fail_code;
        end
        if (state_n != state_q) tmo_cnt_n = '0;
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q    <= S_IDLE;
            n_stb_q    <= '0;
            tmo_q      <= '0;
            oe_en_q    <= 1'b0;
            tmo_cnt_q  <= '0;
            stb_q      <= 1'b0;
            run_det_o  <= 1'b0;
            stb_req_o  <= 1'b0;
            oe_o       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= E_NONE;
            period_o   <= '0;
            stb_cnt_o  <= '0;
        end else begin
            state_q    <= state_n;
            n_stb_q    <= n_stb_n;
            tmo_q      <= tmo_n;
            oe_en_q    <= oe_en_n;
            tmo_cnt_q  <= tmo_cnt_n;
            stb_q      <= stb_i;
            run_det_o  <= state_n inside {S_DETECT, S_ARM, S_RUN};
            stb_req_o  <= state_n inside {S_ARM, S_RUN};
            oe_o       <= (state_n inside {S_ARM, S_RUN}) && oe_en_n;
            busy_o     <= state_n != S_IDLE;
            done_o     <= zdone || (state_n == S_DONE);
            err_o      <= err_n;
            err_code_o <= code_n;
            period_o   <= period_n;
            stb_cnt_o  <= cnt_n;
        end
    end

endmodule

// File: doc/stb_seq_ctrl.md
Name: stb_seq_ctrl

Overview:
Sequencer that drives one stb_gen instance on behalf of the SoC register block. On a start command it enables period detection, latches the measured period, requests strobes, and counts a programmed number of strobe pulses. It then releases the strobe generator and reports completion or a coded error. It sits between the CSR/bus slave and stb_gen; stb_gen's run_det_i, stb_req_i and oe_i are owned exclusively by this block.

Parameters:
T_CNT_WIDTH, 32, width of stb_gen period word and of period_o
N_WIDTH, 16, width of strobe-count request and progress counter
TMO_WIDTH, 32, width of per-phase timeout counter (clk cycles)

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-low
start_i  in  1  single-cycle start command, honoured only in IDLE
abort_i  in  1  single-cycle abort, honoured in any non-IDLE state
n_stb_i  in  N_WIDTH  number of strobes to run, sampled on accepted start
tmo_i  in  TMO_WIDTH  per-phase timeout in cycles, sampled on accepted start; 0 = disabled
oe_en_i  in  1  strobe output enable requested by software, sampled on accepted start
run_det_o  out  1  to stb_gen run_det_i
stb_req_o  out  1  to stb_gen stb_req_i
oe_o  out  1  to stb_gen oe_i
rdy_i  in  1  from stb_gen rdy_o
err_i  in  1  from stb_gen err_o
stb_valid_i  in  1  from stb_gen stb_valid_o
stb_i  in  1  from stb_gen stb_o, clk-synchronous
stb_period_i  in  T_CNT_WIDTH  from stb_gen stb_period_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  sticky error flag, cleared on next accepted start
err_code_o  out  3  0 none, 1 stb_gen err, 2 detect timeout, 3 lock timeout, 4 strobe timeout, 5 lock lost, 6 abort
period_o  out  T_CNT_WIDTH  period latched when rdy_i is seen in DETECT
stb_cnt_o  out  N_WIDTH  strobes counted in current or last run

Behaviour:
- Reset (arst_i low, async): state IDLE; all outputs 0; internal counters 0; stb_i edge register 0.
- All outputs are registered. A state change is visible on the outputs one cycle after the triggering input.
- IDLE: start_i with n_stb_i != 0 latches n_stb, tmo and oe_en; clears err_o, err_code_o, stb_cnt_o and the timeout counter; next state DETECT.
- Start with n_stb_i == 0: no run; done_o pulses next cycle; err_o stays 0.
- start_i outside IDLE is ignored.
- DETECT: run_det_o=1. rdy_i=1 latches stb_period_i into period_o and moves to ARM. err_i=1 goes to ERROR, code 1. Timeout expiry goes to ERROR, code 2.
- ARM: run_det_o=1, stb_req_o=1, oe_o=latched oe_en. stb_valid_i=1 moves to RUN. err_i goes to ERROR, code 1. Timeout goes to ERROR, code 3.
- RUN: same drive as ARM.
  - A rising edge of stb_i (stb_i=1 while the previous sample was 0) increments stb_cnt_o and reloads the timeout counter.
  - When the increment makes stb_cnt_o == n_stb, next state DONE.
  - stb_valid_i=0 goes to ERROR, code 5.
  - err_i goes to ERROR, code 1. Timeout with no edge goes to ERROR, code 4.
- DONE: all drives 0; done_o=1 for exactly one cycle; next state IDLE.
- ERROR: all drives 0; err_o=1; err_code_o set; next state IDLE. There is no done_o on error.
- Timeout counter: reloaded to 0 on every state entry. It increments while in DETECT, ARM or RUN and expires when count == tmo-1. With tmo=0 it never expires.
- Priority within a cycle: abort_i > err_i > phase exit condition (rdy/valid/final edge) > lock lost > timeout.
- Final strobe edge and stb_valid_i falling in the same cycle: counts as DONE.
- abort_i in DETECT/ARM/RUN goes to ERROR, code 6. abort_i in IDLE, DONE or ERROR is ignored.
- stb_cnt_o saturates at all-ones and does not wrap.
- stb_cnt_o and period_o hold their values after the run until the next accepted start.
- Async reset mid-run drops run_det_o, stb_req_o and oe_o immediately.

Test Plan:
- Nominal: n_stb=5, tmo=0, oe_en=1; stb_gen locks on a 20000 ns period at 8 ns clk. Required: period_o latched from rdy; stb_cnt_o counts 1..5; stb_req_o falls one cycle after the 5th edge; done_o pulses once; err_o=0.
- Detect timeout: rdy_i held 0, tmo=100. Required: ERROR at cycle 100 after DETECT entry; err_code_o=2; run_det_o=0; busy_o=0 one cycle later.
- Lock lost: n_stb=10; stb_valid_i forced low after the 3rd strobe. Required: err_code_o=5; stb_cnt_o=3; no done_o.
- Abort in RUN simultaneous with err_i. Required: err_code_o=6 (abort wins); drives drop the next cycle.
- Zero-count start, then start_i pulsed while busy. Required: done_o pulses one cycle after the zero-count start; the second start_i is ignored; n_stb latch is unchanged.
- Async reset asserted in RUN between clock edges. Required: all outputs 0 immediately; the block restarts cleanly on the next start_i.
